// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared stage codes and defaults for the core sequencer
//
// Contents:
//   stage_t          sequencer state / stage code (err_stage uses the same codes)
//   TIMEOUT_DEFAULT  default watchdog limit in cycles
//   stage_busy()     true for the five working stages FETCH..WRITE
package core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WRITE  = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERROR  = 3'd7
    } stage_t;

    localparam int TIMEOUT_DEFAULT = 1024;

    function automatic logic stage_busy(input stage_t s);
        return (s >= ST_FETCH) && (s <= ST_WRITE);
    endfunction

endpackage

// File: rtl/stage_timer.sv
// rtl/stage_timer.sv - clearable per-stage wait counter with timeout flag
//
// Ports:
//   clk      clock
//   rstn     synchronous active-low reset
//   clear    restart the count from zero on the next cycle
//   expired  high while the count equals TIMEOUT-1
module stage_timer
    import core_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    output logic expired
);

    localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    // The count parks at LIMIT; the sequencer leaves the stage on that
    // cycle anyway, so it never needs to wrap.
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - in-order fetch/decode/exec/mem/write core controller
//
// Ports:
//   clk, rstn                      clock, synchronous active-low reset
//   start                          leave IDLE and begin fetching
//   <unit>_en / <unit>_done        one-cycle enable out, one-cycle done in,
//                                  for fetch, decode, exec, mem, write
//   dec_use_mem, dec_halt          decode result flags, valid with decode_done
//   busy, halted, error            status: working, halted, watchdog tripped
//   err_stage                      stage code that timed out
//   cycles, retired                busy-cycle and retired-instruction counters
module stage_sequencer
    import core_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    output logic             fetch_en,
    input  logic             fetch_done,
    output logic             decode_en,
    input  logic             decode_done,
    input  logic             dec_use_mem,
    input  logic             dec_halt,
    output logic             exec_en,
    input  logic             exec_done,
    output logic             mem_en,
    input  logic             mem_done,
    output logic             write_en,
    input  logic             write_done,
    output logic             busy,
    output logic             halted,
    output logic             error,
    output logic [2:0]       err_stage,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] retired
);

    stage_t     state_q, state_d;
    logic       use_mem_q, use_mem_d;
    logic [2:0] err_stage_d;
    logic       retire;
    logic       in_stage;
    logic       entering;
    logic       timed_out;

    assign in_stage = stage_busy(state_q);
    assign entering = (state_d != state_q);

    stage_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (entering || !in_stage),
        .expired (timed_out)
    );

    // A unit's done is only accepted after its enable cycle: the *_en
    // register is high exactly on the first cycle of the stage, so
    // "done && !en" means "done, and not in the enable cycle".
    always_comb begin
        state_d     = state_q;
        use_mem_d   = use_mem_q;
        err_stage_d = err_stage;
        retire      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (fetch_done && !fetch_en) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (decode_done && !decode_en) begin
                    use_mem_d = dec_use_mem;
                    if (dec_halt) begin
                        state_d = ST_HALT;
                        retire  = 1'b1;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (exec_done && !exec_en) state_d = use_mem_q ? ST_MEM : ST_WRITE;
            end
            ST_MEM: begin
                if (mem_done && !mem_en) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (write_done && !write_en) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            default: begin
                // HALT and ERROR hold until reset
            end
        endcase

        // Watchdog only fires when no done moved us on this cycle.
        if (in_stage && (state_d == state_q) && timed_out) begin
            state_d     = ST_ERROR;
            err_stage_d = state_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            use_mem_q <= 1'b0;
            err_stage <= 3'd0;
            cycles    <= '0;
            retired   <= '0;
            fetch_en  <= 1'b0;
            decode_en <= 1'b0;
            exec_en   <= 1'b0;
            mem_en    <= 1'b0;
            write_en  <= 1'b0;
        end else begin
            state_q   <= state_d;
            use_mem_q <= use_mem_d;
            err_stage <= err_stage_d;
            fetch_en  <= entering && (state_d == ST_FETCH);
            decode_en <= entering && (state_d == ST_DECODE);
            exec_en   <= entering && (state_d == ST_EXEC);
            mem_en    <= entering && (state_d == ST_MEM);
            write_en  <= entering && (state_d == ST_WRITE);
            if (in_stage) cycles  <= cycles + CNT_W'(1);
            if (retire)   retired <= retired + CNT_W'(1);
        end
    end

    assign busy   = in_stage;
    assign halted = (state_q == ST_HALT);
    assign error  = (state_q == ST_ERROR);

endmodule
